// File: rtl/pipe_hazard_core.sv
// Hazard detection and forwarding for the stages after decode, driven by per-stage Tnew countdowns.
// Optional PIPE_STALL_CNT_EN adds a 32-bit stall-cycle counter with synchronous clear.
module pipe_hazard_core #(
  parameter int unsigned DW     = 32,
  parameter int unsigned RAW    = 5,
  parameter int unsigned NSTAGE = 3,
  parameter int unsigned NRP    = 2,
  parameter int unsigned TW     = 2
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic                                  flush,
  input  logic                                  id_valid,
  input  logic [NRP*RAW-1:0]                    id_rs,
  input  logic [NRP*TW-1:0]                     id_tuse,
  input  logic [NRP-1:0]                        id_use,
  input  logic [RAW-1:0]                        id_rd,
  input  logic                                  id_wen,
  input  logic [TW-1:0]                         id_tnew,
  input  logic [NSTAGE*DW-1:0]                  stg_res,
  output logic                                  stall,
`ifdef PIPE_STALL_CNT_EN
  input  logic                                  stall_cnt_clr,
  output logic [31:0]                           stall_cnt,
`endif
  output logic [NRP*$clog2(NSTAGE+1)-1:0]       fwd_sel,
  output logic [NRP*DW-1:0]                     fwd_data,
  output logic [NSTAGE-1:0]                     stg_vld,
  output logic [NSTAGE-1:0]                     stg_wen,
  output logic [NSTAGE*RAW-1:0]                 stg_rd
);

  localparam int unsigned SW = $clog2(NSTAGE + 1);

  logic [NSTAGE-1:0]      vld_q, wen_q;
  logic [NSTAGE*RAW-1:0]  rd_q;
  logic [NSTAGE*TW-1:0]   tnew_q;
  logic [NRP-1:0]         stall_req;
  logic                   found;
  logic                   load;

  assign load = ~stall & ~flush;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_q  <= '0;
      wen_q  <= '0;
      rd_q   <= '0;
      tnew_q <= '0;
    end else begin
      vld_q[0]        <= load & id_valid;
      wen_q[0]        <= load & id_wen;
      rd_q[RAW-1:0]   <= load ? id_rd : '0;
      tnew_q[TW-1:0]  <= load ? id_tnew : '0;
      for (int k = 1; k < NSTAGE; k++) begin
        vld_q[k]            <= vld_q[k-1];
        wen_q[k]            <= wen_q[k-1];
        rd_q[k*RAW +: RAW]  <= rd_q[(k-1)*RAW +: RAW];
        tnew_q[k*TW +: TW]  <= (tnew_q[(k-1)*TW +: TW] != '0) ?
                               tnew_q[(k-1)*TW +: TW] - TW'(1) : '0;
      end
    end
  end

  // Youngest matching stage is the producer; older matches are shadowed.
  always_comb begin
    stall_req = '0;
    fwd_sel   = '0;
    fwd_data  = '0;
    found     = 1'b0;
    for (int p = 0; p < NRP; p++) begin
      found = 1'b0;
      for (int k = 0; k < NSTAGE; k++) begin
        if (!found && id_use[p] && vld_q[k] && wen_q[k] &&
            (rd_q[k*RAW +: RAW] == id_rs[p*RAW +: RAW]) && (id_rs[p*RAW +: RAW] != '0)) begin
          found = 1'b1;
          if (tnew_q[k*TW +: TW] == '0) begin
            fwd_sel[p*SW +: SW]  = SW'(k + 1);
            fwd_data[p*DW +: DW] = stg_res[k*DW +: DW];
          end else if (tnew_q[k*TW +: TW] > id_tuse[p*TW +: TW]) begin
            stall_req[p] = 1'b1;
          end
        end
      end
    end
    stall = id_valid & (|stall_req);
  end

  assign stg_vld = vld_q;
  assign stg_wen = wen_q;
  assign stg_rd  = rd_q;

`ifdef PIPE_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_q <= '0;
    end else if (stall_cnt_clr) begin
      stall_cnt_q <= '0;
    end else if (stall) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_core.sv
// Directed self-checking bench for pipe_hazard_core (default parameters).
// Counter checks are compiled only when PIPE_STALL_CNT_EN is defined.
module tb_pipe_hazard_core;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush;
  logic        id_valid;
  logic [9:0]  id_rs;
  logic [3:0]  id_tuse;
  logic [1:0]  id_use;
  logic [4:0]  id_rd;
  logic        id_wen;
  logic [1:0]  id_tnew;
  logic [95:0] stg_res;
  logic        stall;
  logic [3:0]  fwd_sel;
  logic [63:0] fwd_data;
  logic [2:0]  stg_vld;
  logic [2:0]  stg_wen;
  logic [14:0] stg_rd;
`ifdef PIPE_STALL_CNT_EN
  logic        stall_cnt_clr;
  logic [31:0] stall_cnt;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  pipe_hazard_core dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .flush         (flush),
    .id_valid      (id_valid),
    .id_rs         (id_rs),
    .id_tuse       (id_tuse),
    .id_use        (id_use),
    .id_rd         (id_rd),
    .id_wen        (id_wen),
    .id_tnew       (id_tnew),
    .stg_res       (stg_res),
    .stall         (stall),
`ifdef PIPE_STALL_CNT_EN
    .stall_cnt_clr (stall_cnt_clr),
    .stall_cnt     (stall_cnt),
`endif
    .fwd_sel       (fwd_sel),
    .fwd_data      (fwd_data),
    .stg_vld       (stg_vld),
    .stg_wen       (stg_wen),
    .stg_rd        (stg_rd)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] rs0, input logic [1:0] tu0,
                       input logic u0, input logic [4:0] rs1, input logic [1:0] tu1,
                       input logic u1, input logic [4:0] rd, input logic w,
                       input logic [1:0] tn);
    id_valid = v;
    id_rs    = {rs1, rs0};
    id_tuse  = {tu1, tu0};
    id_use   = {u1, u0};
    id_rd    = rd;
    id_wen   = w;
    id_tnew  = tn;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 2'd0, 1'b0, 5'd0, 2'd0, 1'b0, 5'd0, 1'b0, 2'd0);
    flush = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    flush   = 1'b0;
    drive(1'b1, 5'd3, 2'd0, 1'b1, 5'd3, 2'd0, 1'b1, 5'd3, 1'b1, 2'd2);
    repeat (3) tick();
    n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b want 0", stall); end
    n_cmp++; if (stg_vld !== 3'b000) begin n_fail++; $display("FAIL reset_vld got %b want 000", stg_vld); end
    n_cmp++; if (fwd_sel !== 4'h0) begin n_fail++; $display("FAIL reset_sel got %h want 0", fwd_sel); end
    n_cmp++; if (fwd_data !== 64'h0) begin n_fail++; $display("FAIL reset_data got %h want 0", fwd_data); end
    drive(1'b0, 5'd0, 2'd0, 1'b0, 5'd0, 2'd0, 1'b0, 5'd0, 1'b0, 2'd0);
    reset_n = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_forward();
    idle();
    drive(1'b1, 5'd0, 2'd0, 1'b0, 5'd0, 2'd0, 1'b0, 5'd3, 1'b1, 2'd0);
    tick();
    drive(1'b1, 5'd3, 2'd1, 1'b1, 5'd7, 2'd1, 1'b1, 5'd8, 1'b1, 2'd0);
    #1;
    n_cmp++; if (fwd_sel[1:0] !== 2'd1) begin n_fail++; $display("FAIL fwd_sel0 got %0d want 1", fwd_sel[1:0]); end
    n_cmp++; if (fwd_data[31:0] !== 32'h0000_0005) begin n_fail++; $display("FAIL fwd_data0 got %h want 00000005", fwd_data[31:0]); end
    n_cmp++; if (fwd_sel[3:2] !== 2'd0) begin n_fail++; $display("FAIL fwd_sel1_nomatch got %0d want 0", fwd_sel[3:2]); end
    n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL fwd_stall got %b want 0", stall); end
  endtask

  task automatic test_load_use();
    idle();
    drive(1'b1, 5'd0, 2'd0, 1'b0, 5'd0, 2'd0, 1'b0, 5'd4, 1'b1, 2'd2);
    tick();
    drive(1'b1, 5'd4, 2'd0, 1'b1, 5'd0, 2'd0, 1'b1, 5'd0, 1'b0, 2'd0);
    #1;
    n_cmp++; if (stall !== 1'b1) begin n_fail++; $display("FAIL lu_stall1 got %b want 1", stall); end
    n_cmp++; if (fwd_sel[1:0] !== 2'd0) begin n_fail++; $display("FAIL lu_sel1 got %0d want 0", fwd_sel[1:0]); end
    tick();
    n_cmp++; if (stall !== 1'b1) begin n_fail++; $display("FAIL lu_stall2 got %b want 1", stall); end
    n_cmp++; if (stg_vld !== 3'b010) begin n_fail++; $display("FAIL lu_vld2 got %b want 010", stg_vld); end
    tick();
    n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL lu_stall3 got %b want 0", stall); end
    n_cmp++; if (fwd_sel[1:0] !== 2'd3) begin n_fail++; $display("FAIL lu_sel3 got %0d want 3", fwd_sel[1:0]); end
    n_cmp++; if (fwd_data[31:0] !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL lu_data3 got %h want deadbeef", fwd_data[31:0]); end
    n_cmp++; if (stg_vld !== 3'b100) begin n_fail++; $display("FAIL lu_vld3 got %b want 100", stg_vld); end
  endtask

  task automatic test_tuse_boundary();
    idle();
    drive(1'b1, 5'd0, 2'd0, 1'b0, 5'd0, 2'd0, 1'b0, 5'd4, 1'b1, 2'd2);
    tick();
    drive(1'b1, 5'd0, 2'd0, 1'b0, 5'd4, 2'd1, 1'b1, 5'd9, 1'b1, 2'd1);
    #1;
    n_cmp++; if (stall !== 1'b1) begin n_fail++; $display("FAIL tb_stall got %b want 1", stall); end
    tick();
    n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL tb_nostall got %b want 0", stall); end
    n_cmp++; if (fwd_sel[3:2] !== 2'd0) begin n_fail++; $display("FAIL tb_sel got %0d want 0", fwd_sel[3:2]); end
  endtask

  task automatic test_youngest();
    idle();
    drive(1'b1, 5'd0, 2'd0, 1'b0, 5'd0, 2'd0, 1'b0, 5'd5, 1'b1, 2'd0);
    tick();
    tick();
    drive(1'b1, 5'd5, 2'd1, 1'b1, 5'd5, 2'd0, 1'b1, 5'd0, 1'b0, 2'd0);
    #1;
    n_cmp++; if (fwd_sel[1:0] !== 2'd1) begin n_fail++; $display("FAIL young_sel0 got %0d want 1", fwd_sel[1:0]); end
    n_cmp++; if (fwd_sel[3:2] !== 2'd1) begin n_fail++; $display("FAIL young_sel1 got %0d want 1", fwd_sel[3:2]); end
    n_cmp++; if (fwd_data[63:32] !== 32'h0000_0005) begin n_fail++; $display("FAIL young_data1 got %h want 00000005", fwd_data[63:32]); end
  endtask

  task automatic test_zero_reg();
    idle();
    drive(1'b1, 5'd0, 2'd0, 1'b0, 5'd0, 2'd0, 1'b0, 5'd0, 1'b1, 2'd2);
    tick();
    drive(1'b1, 5'd0, 2'd0, 1'b1, 5'd0, 2'd0, 1'b1, 5'd0, 1'b0, 2'd0);
    #1;
    n_cmp++; if (stg_vld[0] !== 1'b1) begin n_fail++; $display("FAIL zero_vld got %b want 1", stg_vld[0]); end
    n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL zero_stall got %b want 0", stall); end
    n_cmp++; if (fwd_sel !== 4'h0) begin n_fail++; $display("FAIL zero_sel got %h want 0", fwd_sel); end
  endtask

  task automatic test_reset_mid_stall();
    idle();
    drive(1'b1, 5'd0, 2'd0, 1'b0, 5'd0, 2'd0, 1'b0, 5'd4, 1'b1, 2'd2);
    tick();
    drive(1'b1, 5'd4, 2'd0, 1'b1, 5'd0, 2'd0, 1'b1, 5'd0, 1'b0, 2'd0);
    tick();
    n_cmp++; if (stall !== 1'b1) begin n_fail++; $display("FAIL mid_pre got %b want 1", stall); end
    reset_n = 1'b0;
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL mid_async_stall got %b want 0", stall); end
    n_cmp++; if (stg_vld !== 3'b000) begin n_fail++; $display("FAIL mid_async_vld got %b want 000", stg_vld); end
    reset_n = 1'b1;
    tick();
    n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL mid_release got %b want 0", stall); end
  endtask

  task automatic test_flush();
    idle();
    drive(1'b1, 5'd0, 2'd0, 1'b0, 5'd0, 2'd0, 1'b0, 5'd6, 1'b1, 2'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_cmp++; if (stg_vld[0] !== 1'b0) begin n_fail++; $display("FAIL flush_vld got %b want 0", stg_vld[0]); end
    n_cmp++; if (stg_rd[4:0] !== 5'd0) begin n_fail++; $display("FAIL flush_rd got %0d want 0", stg_rd[4:0]); end
    tick();
    n_cmp++; if (stg_vld[0] !== 1'b1 || stg_rd[4:0] !== 5'd6) begin n_fail++; $display("FAIL load_rd got %b/%0d want 1/6", stg_vld[0], stg_rd[4:0]); end
    // flush during a stall cycle: stage 0 still takes a bubble
    drive(1'b1, 5'd0, 2'd0, 1'b0, 5'd0, 2'd0, 1'b0, 5'd4, 1'b1, 2'd2);
    tick();
    drive(1'b1, 5'd4, 2'd0, 1'b1, 5'd0, 2'd0, 1'b0, 5'd0, 1'b0, 2'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_cmp++; if (stg_vld[1:0] !== 2'b10) begin n_fail++; $display("FAIL flush_stall got %b want 10", stg_vld[1:0]); end
  endtask

`ifdef PIPE_STALL_CNT_EN
  task automatic test_stall_cnt();
    idle();
    stall_cnt_clr = 1'b1;
    tick();
    stall_cnt_clr = 1'b0;
    drive(1'b1, 5'd0, 2'd0, 1'b0, 5'd0, 2'd0, 1'b0, 5'd4, 1'b1, 2'd3);
    tick();
    drive(1'b1, 5'd4, 2'd0, 1'b1, 5'd0, 2'd0, 1'b0, 5'd0, 1'b0, 2'd0);
    repeat (4) tick();
    n_cmp++; if (stall_cnt !== 32'd3) begin n_fail++; $display("FAIL cnt3 got %0d want 3", stall_cnt); end
    drive(1'b1, 5'd0, 2'd0, 1'b0, 5'd0, 2'd0, 1'b0, 5'd4, 1'b1, 2'd3);
    tick();
    drive(1'b1, 5'd4, 2'd0, 1'b1, 5'd0, 2'd0, 1'b0, 5'd0, 1'b0, 2'd0);
    stall_cnt_clr = 1'b1;
    tick();
    stall_cnt_clr = 1'b0;
    n_cmp++; if (stall_cnt !== 32'd0) begin n_fail++; $display("FAIL cnt_clr got %0d want 0", stall_cnt); end
  endtask
`endif

  initial begin
    stg_res = {32'hDEAD_BEEF, 32'h0000_00AA, 32'h0000_0005};
`ifdef PIPE_STALL_CNT_EN
    stall_cnt_clr = 1'b0;
`endif
    test_reset();
    test_forward();
    test_load_use();
    test_tuse_boundary();
    test_youngest();
    test_zero_reg();
    test_reset_mid_stall();
    test_flush();
`ifdef PIPE_STALL_CNT_EN
    test_stall_cnt();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_core.md
# pipe_hazard_core

Parametrised hazard-detection and forwarding core for the MIPS pipeline. It tracks the producer state of every instruction in flight past decode (E, M, W, … up to `NSTAGE` stages) using a per-stage Tnew countdown. It compares that state against the decode-stage source registers and their Tuse, and from that produces the decode stall, the ID/EX bubble, and the per-read-port forwarding selects and data. It replaces the fixed two-port, hard-wired MD/ME/WD/WE/WM mux scheme and its externally computed forward enables.

## Interface
- `DW`, 32, datapath width
- `RAW`, 5, register-address width
- `NSTAGE`, 3, tracked stages after decode (index 0 = E … NSTAGE-1 = W)
- `NRP`, 2, decode read ports
- `TW`, 2, Tnew/Tuse field width
- `clk` in 1: rising-edge clock
- `reset_n` in 1: reset, asynchronous, active-low
- `flush` in 1: synchronous; kills the instruction entering stage 0 this cycle
- `id_valid` in 1: decode holds a real instruction
- `id_rs` in NRP*RAW: source register per port (port p at bits [p*RAW +: RAW])
- `id_tuse` in NRP*TW: cycles until port p value is consumed (0 = needed in decode)
- `id_use` in NRP: port p actually reads its register
- `id_rd` in RAW: destination register
- `id_wen` in 1: instruction writes `id_rd`
- `id_tnew` in TW: cycles from entry into stage 0 until its result is valid
- `stg_res` in NSTAGE*DW: result currently presented by each stage datapath
- `stall` out 1: hold PC and IF/ID; stage 0 receives a bubble
- `fwd_sel` out NRP*$clog2(NSTAGE+1): 0 = use register file, k+1 = forward from stage k
- `fwd_data` out NRP*DW: forwarded value for port p (0 when `fwd_sel`=0)
- `stg_vld` out NSTAGE: stage holds a real instruction
- `stg_wen` out NSTAGE: stage instruction writes a register
- `stg_rd` out NSTAGE*RAW: stage destination register

## Operation
- Each stage record holds vld, wen, rd, and tnew. Records shift from stage k to stage k+1 every cycle, and the stage NSTAGE-1 record retires. No hold exists beyond decode.
- Stage 0 load:
  - Loads {id_valid, id_wen, id_rd, id_tnew} when `stall`=0 and `flush`=0.
  - Otherwise loads a bubble: vld=0, wen=0, rd=0, tnew=0.
- tnew decrements by 1 per shift and saturates at 0.
- Match for port p at stage k: `id_use[p]` & `stg_vld[k]` & `stg_wen[k]` & (`stg_rd[k]` == `id_rs[p]`) & (`id_rs[p]` != 0).
- Producer for port p is the lowest-index (youngest) matching stage. Older matches are ignored.
- Per-port forwarding and stall:
  - Producer tnew == 0: `fwd_sel` = k+1 and `fwd_data` = `stg_res[k]`.
  - Producer tnew > 0 and tnew > `id_tuse[p]`: the port requests a stall and `fwd_sel` = 0.
  - Producer tnew > 0 and tnew ≤ `id_tuse[p]`: no stall and `fwd_sel` = 0. A later stage forwards the value.
  - No producer: `fwd_sel` = 0.
- `stall` = `id_valid` & OR of all per-port stall requests.
- Register $0 is never forwarded and never causes a stall.

## Timing
- `stall`, `fwd_sel`, and `fwd_data` are combinational from stage registers plus `id_*` and `stg_res`. There are no registered outputs on these paths.
- `stg_vld`, `stg_wen`, `stg_rd`, and the internal tnew values are registered and update on the `clk` rising edge.
- Reset (`reset_n`=0, asynchronous): every stage record clears to vld=0, wen=0, rd=0, tnew=0. As a result `stall`=0, all `fwd_sel`=0, and all `fwd_data`=0.
- Reset asserted mid-stall clears all records immediately. The first cycle after release has no stall.
- `flush` and `stall` in the same cycle: stage 0 gets a bubble; the result is identical either way.
- A stall lasts exactly until the producer tnew ≤ Tuse. With the default config, a load (tnew 2) followed by a beq (tuse 0) stalls 2 cycles.

## Configuration
- `PIPE_STALL_CNT_EN`
- Defined:
  - Adds output `stall_cnt` (32-bit), which increments on every cycle with `stall`=1 and wraps from 0xFFFFFFFF to 0.
  - Adds input `stall_cnt_clr`, a synchronous clear that takes priority over increment.
  - `stall_cnt` resets to 0.
- Undefined: neither port exists and there is no counter logic. All other behaviour is identical.

## Test plan
- Reset with all inputs active → `stall`=0, `stg_vld`=000, every `fwd_sel`=0. After release, issue `addu $3` (tnew 0) then `addu` reading $3 (tuse 1) → `fwd_sel[0]`=1 and `fwd_data` = `stg_res[0]` (0x0000_0005).
- `lw $4` (tnew 2) then `beq $4,$0` (tuse 0) → `stall`=1 for 2 cycles. Stage 0 holds bubbles, then `fwd_sel`=3 (W) with data 0xDEAD_BEEF.
- `addu $5` at stage 0 and an older `addu $5` at stage 1, both tnew 0 → `fwd_sel`=1 (youngest wins).
- Producer writes $0 with tnew 2 against a tuse 0 reader of $0 → `stall`=0 and `fwd_sel`=0.
- Assert `reset_n` low during the second stall cycle of the `lw` case → `stall` drops to 0 asynchronously and all records clear. `flush` with `id_valid`=1 → `stg_vld[0]`=0 next cycle.
- `PIPE_STALL_CNT_EN` defined: 3 stall cycles give `stall_cnt`=3. Then assert `stall_cnt_clr` during a stall cycle → 0. Preload near wrap → 0xFFFFFFFF+1 = 0.
